// File: rtl/riscv_lsu.sv
// Load-store unit between the MEM stage and a byte-addressable data memory.
// Aligned accesses pass straight through; misaligned ones are split into byte accesses.
module riscv_lsu #(
    parameter int ADDR_W = 64
) (
    input  logic              i_riscv_lsu_clk,
    input  logic              i_riscv_lsu_rst,
    input  logic              i_riscv_lsu_req,
    input  logic              i_riscv_lsu_we,
    input  logic [1:0]        i_riscv_lsu_size,
    input  logic              i_riscv_lsu_unsigned,
    input  logic [ADDR_W-1:0] i_riscv_lsu_addr,
    input  logic [63:0]       i_riscv_lsu_wdata,
    output logic [63:0]       o_riscv_lsu_rdata,
    output logic              o_riscv_lsu_done,
    output logic              o_riscv_lsu_stall,
    output logic              o_riscv_lsu_dm_wen,
    output logic [1:0]        o_riscv_lsu_dm_sel,
    output logic [ADDR_W-1:0] o_riscv_lsu_dm_addr,
    output logic [63:0]       o_riscv_lsu_dm_wdata,
    input  logic [63:0]       i_riscv_lsu_dm_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        SPLIT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       buf_q, buf_d;
    logic [63:0]       rdata_q, rdata_d;

    logic       accept;
    logic       misaligned;
    logic [2:0] last_idx;

    // Sign- or zero-extend the low 8*N bits of a little-endian value.
    function automatic logic [63:0] extend(input logic [63:0] v, input logic [1:0] size,
                                           input logic uns);
        case (size)
            2'b00:   extend = uns ? {56'b0, v[7:0]}  : {{56{v[7]}}, v[7:0]};
            2'b01:   extend = uns ? {48'b0, v[15:0]} : {{48{v[15]}}, v[15:0]};
            2'b10:   extend = uns ? {32'b0, v[31:0]} : {{32{v[31]}}, v[31:0]};
            default: extend = v;
        endcase
    endfunction

    // A request arriving while reset is held must not reach the memory.
    assign accept = i_riscv_lsu_req & ~i_riscv_lsu_rst;

    always_comb begin
        case (i_riscv_lsu_size)
            2'b01:   misaligned = i_riscv_lsu_addr[0];
            2'b10:   misaligned = |i_riscv_lsu_addr[1:0];
            2'b11:   misaligned = |i_riscv_lsu_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b01:   last_idx = 3'd1;
            2'b10:   last_idx = 3'd3;
            2'b11:   last_idx = 3'd7;
            default: last_idx = 3'd0;
        endcase
    end

    always_comb begin
        // NOTE: every signal assigned below gets a default first, so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        buf_d    = buf_q;
        rdata_d  = rdata_q;

        o_riscv_lsu_dm_wen   = 1'b0;
        o_riscv_lsu_dm_sel   = i_riscv_lsu_size;
        o_riscv_lsu_dm_addr  = i_riscv_lsu_addr;
        o_riscv_lsu_dm_wdata = i_riscv_lsu_wdata;
        o_riscv_lsu_done     = 1'b0;
        o_riscv_lsu_stall    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!misaligned) begin
                        o_riscv_lsu_dm_wen = i_riscv_lsu_we;
                        o_riscv_lsu_done   = 1'b1;
                        if (!i_riscv_lsu_we) begin
                            rdata_d = extend(i_riscv_lsu_dm_rdata, i_riscv_lsu_size,
                                             i_riscv_lsu_unsigned);
                        end
                    end else begin
                        we_d    = i_riscv_lsu_we;
                        size_d  = i_riscv_lsu_size;
                        uns_d   = i_riscv_lsu_unsigned;
                        addr_d  = i_riscv_lsu_addr;
                        wdata_d = i_riscv_lsu_wdata;
                        buf_d   = {56'b0, i_riscv_lsu_dm_rdata[7:0]};
                        cnt_d   = 3'd1;
                        state_d = SPLIT;

                        o_riscv_lsu_dm_sel = 2'b00;
                        o_riscv_lsu_dm_wen = i_riscv_lsu_we;
                        o_riscv_lsu_stall  = 1'b1;
                    end
                end
            end

            SPLIT: begin
                o_riscv_lsu_dm_sel   = 2'b00;
                o_riscv_lsu_dm_addr  = addr_q + ADDR_W'(cnt_q);
                o_riscv_lsu_dm_wdata = wdata_q >> {cnt_q, 3'b000};
                o_riscv_lsu_dm_wen   = we_q;
                o_riscv_lsu_stall    = 1'b1;
                if (!we_q) begin
                    buf_d[{cnt_q, 3'b000} +: 8] = i_riscv_lsu_dm_rdata[7:0];
                end
                if (cnt_q == last_idx) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            DONE: begin
                o_riscv_lsu_done = 1'b1;
                if (!we_q) begin
                    rdata_d = extend(buf_q, size_q, uns_q);
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // The result bus shows the value being retired this cycle, otherwise the last one.
    assign o_riscv_lsu_rdata = rdata_d;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_riscv_lsu_clk or posedge i_riscv_lsu_rst) begin
        if (i_riscv_lsu_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu with a byte-array data memory and a result scoreboard.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        done;
    logic        stall;
    logic        dm_wen;
    logic [1:0]  dm_sel;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic [63:0] dm_rdata;

    logic [7:0]  mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr;
    logic [7:0]  pl_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [63:0] rdata;
        int          n_stall;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] last_rdata = 64'd0;

    riscv_lsu #(.ADDR_W(64)) dut (
        .i_riscv_lsu_clk      (clk),
        .i_riscv_lsu_rst      (rst),
        .i_riscv_lsu_req      (req),
        .i_riscv_lsu_we       (we),
        .i_riscv_lsu_size     (size),
        .i_riscv_lsu_unsigned (uns),
        .i_riscv_lsu_addr     (addr),
        .i_riscv_lsu_wdata    (wdata),
        .o_riscv_lsu_rdata    (rdata),
        .o_riscv_lsu_done     (done),
        .o_riscv_lsu_stall    (stall),
        .o_riscv_lsu_dm_wen   (dm_wen),
        .o_riscv_lsu_dm_sel   (dm_sel),
        .o_riscv_lsu_dm_addr  (dm_addr),
        .o_riscv_lsu_dm_wdata (dm_wdata),
        .i_riscv_lsu_dm_rdata (dm_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous write of (1<<sel) bytes, combinational 8-byte read.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] = pl_data;
        if (dm_wen) begin
            for (int i = 0; i < 8; i++) begin
                if (i < (1 << dm_sel)) mem[8'(dm_addr[7:0] + 8'(i))] = dm_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        dm_rdata = '0;
        for (int i = 0; i < 8; i++) dm_rdata[8*i +: 8] = mem[8'(dm_addr[7:0] + 8'(i))];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic scramble();
        req   = 1'b0;
        we    = 1'($urandom_range(0, 1));
        size  = 2'($urandom_range(0, 3));
        uns   = 1'($urandom_range(0, 1));
        addr  = {$urandom, $urandom};
        wdata = {$urandom, $urandom};
    endtask

    // Issue one access, then follow it cycle by cycle until done, checking each byte beat.
    task automatic access(input string tag, input logic a_we, input logic [1:0] a_size,
                          input logic a_uns, input logic [63:0] a_addr,
                          input logic [63:0] a_wdata, input logic [63:0] exp_rdata);
        exp_t e;
        exp_t p;
        int   stalls;
        logic got;
        logic mis;
        mis       = (a_size != 2'b00) && ((a_addr % (64'd1 << a_size)) != 64'd0);
        e.tag     = tag;
        e.rdata   = a_we ? last_rdata : exp_rdata;
        e.n_stall = mis ? (1 << a_size) : 0;
        sb.push_back(e);
        if (!a_we) last_rdata = exp_rdata;

        @(negedge clk);
        req = 1'b1; we = a_we; size = a_size; uns = a_uns; addr = a_addr; wdata = a_wdata;
        got    = 1'b0;
        stalls = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            if (done) begin
                p = sb.pop_front();
                check({p.tag, "_rdata"}, rdata, p.rdata);
                check({p.tag, "_nstall"}, 64'(stalls), 64'(p.n_stall));
                check({p.tag, "_stall_at_done"}, 64'(stall), 64'd0);
                got = 1'b1;
            end else begin
                check({tag, "_stall"}, 64'(stall), 64'd1);
                check({tag, "_beat_addr"}, dm_addr, a_addr + 64'(stalls));
                check({tag, "_beat_sel"}, 64'(dm_sel), 64'd0);
                check({tag, "_beat_wen"}, 64'(dm_wen), 64'(a_we));
                if (a_we) check({tag, "_beat_wdata"}, 64'(dm_wdata[7:0]),
                                64'(a_wdata[8*stalls +: 8]));
                stalls++;
                @(posedge clk);
                #1 scramble();
                @(negedge clk);
            end
        end
        check({tag, "_completed"}, 64'(got), 64'd1);
        if (!got) sb.delete();
        @(posedge clk);
        #1 scramble();
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
        addr = 64'd0; wdata = 64'd0;
        #1;
        check("rst_rdata", rdata, 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_wen", 64'(dm_wen), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Aligned dword round trip.
        access("t1_sd", 1'b1, 2'b11, 1'b0, 64'h10, 64'h1122334455667788, 64'd0);
        access("t1_ld", 1'b0, 2'b11, 1'b0, 64'h10, 64'd0, 64'h1122334455667788);

        // Misaligned word loads, signed and unsigned.
        poke(8'h13, 8'h80); poke(8'h14, 8'h00); poke(8'h15, 8'h00); poke(8'h16, 8'h90);
        access("t2_lw", 1'b0, 2'b10, 1'b0, 64'h13, 64'd0, 64'hFFFFFFFF90000080);
        access("t2_lwu", 1'b0, 2'b10, 1'b1, 64'h13, 64'd0, 64'h0000000090000080);
        access("t2_lh", 1'b0, 2'b01, 1'b0, 64'h15, 64'd0, 64'hFFFFFFFFFFFF9000);

        // Misaligned half store must touch exactly two bytes.
        poke(8'h20, 8'h5A); poke(8'h21, 8'h00); poke(8'h22, 8'h00); poke(8'h23, 8'hA5);
        access("t3_sh", 1'b1, 2'b01, 1'b0, 64'h21, 64'h55555555_5555ABCD, 64'd0);
        check("t3_m20", 64'(mem[8'h20]), 64'h5A);
        check("t3_m21", 64'(mem[8'h21]), 64'hCD);
        check("t3_m22", 64'(mem[8'h22]), 64'hAB);
        check("t3_m23", 64'(mem[8'h23]), 64'hA5);

        // Misaligned dword load with core inputs scrambled during the split.
        for (int i = 0; i < 8; i++) poke(8'(8'h07 + i), 8'(i + 1));
        access("t4_ld", 1'b0, 2'b11, 1'b0, 64'h07, 64'd0, 64'h0807060504030201);

        // Reset in the middle of a misaligned word store.
        poke(8'h30, 8'h55); poke(8'h31, 8'h11); poke(8'h32, 8'h22);
        poke(8'h33, 8'h33); poke(8'h34, 8'h44);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; addr = 64'h31; wdata = 64'hDDCCBBAA;
        #1;
        check("t5_b0_addr", dm_addr, 64'h31);
        check("t5_b0_wen", 64'(dm_wen), 64'd1);
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        #1;
        check("t5_b1_addr", dm_addr, 64'h32);
        check("t5_b1_stall", 64'(stall), 64'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_stall", 64'(stall), 64'd0);
        check("t5_rst_wen", 64'(dm_wen), 64'd0);
        check("t5_rst_done", 64'(done), 64'd0);
        check("t5_rst_rdata", rdata, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_rdata = 64'd0;
        check("t5_m30", 64'(mem[8'h30]), 64'h55);
        check("t5_m31", 64'(mem[8'h31]), 64'hAA);
        check("t5_m32", 64'(mem[8'h32]), 64'h22);
        check("t5_m33", 64'(mem[8'h33]), 64'h33);
        check("t5_m34", 64'(mem[8'h34]), 64'h44);
        access("t5_post_lb", 1'b0, 2'b00, 1'b0, 64'h31, 64'd0, 64'hFFFFFFFFFFFFFFAA);

        // Byte loads are always single cycle.
        poke(8'h05, 8'hFE);
        access("t6_lb", 1'b0, 2'b00, 1'b0, 64'h05, 64'd0, 64'hFFFFFFFFFFFFFFFE);
        access("t6_lbu", 1'b0, 2'b00, 1'b1, 64'h05, 64'd0, 64'h00000000000000FE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load-store unit on the core side of the data-memory interface. It drives the memory's Wen/sel/addr/wdata bus and consumes its rdata. Naturally aligned accesses pass through in a single cycle. Misaligned halfword, word and doubleword accesses are split into sequential byte accesses under a small FSM, and the pipeline is stalled until the access completes. Load data is sign- or zero-extended to 64 bits.

Parameters:
ADDR_W, 64, address width of the core and memory address buses

Ports:
i_riscv_lsu_clk  in  1  clock; the data memory writes on the same rising edge
i_riscv_lsu_rst  in  1  asynchronous reset, active-high
i_riscv_lsu_req  in  1  memory access request from the MEM stage
i_riscv_lsu_we  in  1  1 = store, 0 = load
i_riscv_lsu_size  in  2  access size: 00 byte, 01 half, 10 word, 11 dword
i_riscv_lsu_unsigned  in  1  load zero-extend (LBU/LHU/LWU); ignored for dword and for stores
i_riscv_lsu_addr  in  ADDR_W  byte address
i_riscv_lsu_wdata  in  64  store data, right-justified
o_riscv_lsu_rdata  out  64  extended load result
o_riscv_lsu_done  out  1  access complete this cycle
o_riscv_lsu_stall  out  1  hold the pipeline
o_riscv_lsu_dm_wen  out  1  memory write enable
o_riscv_lsu_dm_sel  out  2  memory size select, same encoding as size
o_riscv_lsu_dm_addr  out  ADDR_W  memory byte address
o_riscv_lsu_dm_wdata  out  64  memory write data; low (8<<sel) bits are used
i_riscv_lsu_dm_rdata  in  64  memory read data; combinational read, low (8<<sel) bits are valid

Behaviour:
- Memory contract: write is synchronous on the rising clock edge when dm_wen=1. Read is combinational from dm_addr/dm_sel.
- Misaligned condition: size!=00 and addr[size-1:0]!=0. Byte accesses are always aligned. N = 1<<size.
- FSM states: IDLE, SPLIT, DONE. Reset value is IDLE.
- Reset values: all registers cleared, rdata=0, done=0, stall=0, dm_wen=0.
- IDLE, no req: dm_wen=0; dm_addr/sel/wdata mirror the core inputs; done=0; stall=0.
- IDLE, req, aligned (pass-through):
  - dm_wen=we, dm_sel=size, dm_addr=addr, dm_wdata=wdata.
  - done=1 and stall=0 in the same cycle.
  - rdata is the combinational extension of dm_rdata. Stays in IDLE.
- IDLE, req, misaligned:
  - Latch we, size, unsigned, addr and wdata. Set cnt=0.
  - Issue byte 0: dm_sel=00, dm_addr=addr, dm_wdata=wdata, dm_wen=we.
  - stall=1. Next state is SPLIT with cnt=1.
  - For a load, dm_rdata[7:0] is captured into byte lane 0 of the 64-bit buffer.
- SPLIT, per cycle:
  - Issue byte cnt from latched values: dm_sel=00, dm_addr=addr_q+cnt (wraps modulo 2^ADDR_W), dm_wdata=wdata_q>>(8*cnt), dm_wen=we_q.
  - Loads capture dm_rdata[7:0] into buffer lane cnt.
  - stall=1 throughout.
  - If cnt==N-1, next state is DONE; otherwise cnt+1.
- SPLIT, input handling: core inputs are ignored while in SPLIT; only latched values are used.
- DONE (one cycle):
  - done=1, stall=0, dm_wen=0.
  - rdata = registered extension of the buffer.
  - req is ignored (it is the retiring access). Next state is IDLE.
- Misaligned timing: stall is high for N cycles and done arrives in cycle N+1.
  - Half: 2+1 cycles. Word: 4+1 cycles. Dword: 8+1 cycles.
- Load extension (little-endian):
  - The value is the low (8*N) bits.
  - Signed: replicate bit 8*N-1 up to bit 63.
  - Unsigned: zero-fill. Dword: no extension.
- Stores: rdata holds its previous value; done still pulses.
- Reset mid-access: outputs go to reset values immediately (asynchronously) and the FSM returns to IDLE. No further dm_wen is issued. Bytes already written stay written and are not rolled back.
- Byte-lane order: ascending address equals ascending lane. No byte is written twice.

Test Plan:
1. Aligned dword store at 0x10 with wdata 0x1122334455667788, then load at 0x10 -> each access completes in 1 cycle with done=1 and stall never high; load rdata = 0x1122334455667788.
2. Memory bytes 0x13..0x16 = 80,00,00,90; signed word load at 0x13 -> stall 4 cycles, dm_addr 0x13,0x14,0x15,0x16 with sel=00; done in cycle 5 with rdata 0xFFFFFFFF90000080. Same access as LWU -> rdata 0x0000000090000080.
3. Half store at 0x21 with wdata 0xABCD -> two cycles with dm_wen=1, sel=00: 0x21<-CD then 0x22<-AB; neighbouring bytes 0x20 and 0x23 unchanged; done in cycle 3.
4. Dword load at 0x07 over bytes 0x01..0x08 -> 8 byte reads at 0x07..0x0E, rdata = 0x0807060504030201; core inputs changed during SPLIT have no effect.
5. Misaligned word store at 0x31 with wdata 0xDDCCBBAA; assert reset during the cycle addressing 0x32 (before its clock edge) -> stall and dm_wen drop at once; memory 0x31=AA; 0x32..0x34 unchanged; next request is accepted from IDLE.
6. Signed byte load at 0x05 with memory byte = FE -> single cycle, no stall, rdata = 0xFFFFFFFFFFFFFFFE; LBU -> 0x00000000000000FE.
